// File: rtl/acc_pkg.sv
// Shared types and helpers for the accelerator response writeback stage.
package acc_pkg;

    localparam int RegAddrWidth = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } wb_state_e;

    // Second beat of a dual writeback targets the next register; x31 wraps to x0.
    function automatic logic [RegAddrWidth-1:0] rd_plus_one(input logic [RegAddrWidth-1:0] rd);
        return rd + 5'd1;
    endfunction

endpackage

// File: rtl/acc_rsp_rr_arb.sv
// NumRsp-way round-robin arbiter; owns the rotating priority pointer.
module acc_rsp_rr_arb #(
    parameter  int NumRsp = 2,
    localparam int IdxW   = (NumRsp > 1) ? $clog2(NumRsp) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumRsp-1:0] req_i,
    input  logic              advance_i,
    output logic [NumRsp-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] ptr_d;
    logic [IdxW-1:0] cand_s;

    // Search requests starting at the pointer and take the first one found.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        for (int off = 0; off < NumRsp; off++) begin
            cand_s = IdxW'((int'(ptr_q) + off) % NumRsp);
            if (!valid_o && req_i[cand_s]) begin
                valid_o = 1'b1;
                idx_o   = cand_s;
            end else begin
                valid_o = valid_o;
            end
        end
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

    assign ptr_d = IdxW'((int'(idx_o) + 1) % NumRsp);

    // Pointer moves past the winner only when the grant is actually taken.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end else begin
            ptr_q <= ptr_q;
        end
    end

endmodule

// File: rtl/acc_rsp_wb_arbiter.sv
// Arbitrates accelerator responses and serialises them into register-file writeback beats.
// Define ACC_RSP_DUAL_WB_EN to split dual-writeback responses into rd / rd+1 beats.
module acc_rsp_wb_arbiter
    import acc_pkg::*;
#(
    parameter  int NumRsp    = 2,
    parameter  int DataWidth = 32,
    parameter  int IdWidth   = 4,
    localparam int IdxW      = (NumRsp > 1) ? $clog2(NumRsp) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumRsp*DataWidth-1:0] p_data0_i,
    input  logic [NumRsp*DataWidth-1:0] p_data1_i,
    input  logic [NumRsp-1:0]           p_dual_wb_i,
    input  logic [NumRsp*IdWidth-1:0]   p_id_i,
    input  logic [NumRsp*5-1:0]         p_rd_i,
    input  logic [NumRsp-1:0]           p_error_i,
    input  logic [NumRsp-1:0]           p_valid_i,
    output logic [NumRsp-1:0]           p_ready_o,
    output logic [DataWidth-1:0]        wb_data_o,
    output logic [4:0]                  wb_rd_o,
    output logic [IdWidth-1:0]          wb_id_o,
    output logic                        wb_error_o,
    output logic                        wb_last_o,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i
);

    wb_state_e                 state_q;
    logic [DataWidth-1:0]      wb_data_q;
    logic [RegAddrWidth-1:0]   wb_rd_q;
    logic [IdWidth-1:0]        wb_id_q;
    logic                      wb_error_q;
    logic                      wb_last_q;
    logic                      wb_valid_q;

    logic [NumRsp-1:0]         gnt_s;
    logic [IdxW-1:0]           gnt_idx_s;
    logic                      gnt_valid_s;
    logic                      cap_slot_s;
    logic                      capture_s;

    logic [DataWidth-1:0]      sel_data0_s;
    logic [RegAddrWidth-1:0]   sel_rd_s;
    logic [IdWidth-1:0]        sel_id_s;
    logic                      sel_dual_s;
    logic                      sel_err_s;

    acc_rsp_rr_arb #(.NumRsp(NumRsp)) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (p_valid_i),
        .advance_i (capture_s),
        .gnt_o     (gnt_s),
        .idx_o     (gnt_idx_s),
        .valid_o   (gnt_valid_s)
    );

    // The holding register is free when idle or when its last beat leaves this cycle.
    assign cap_slot_s = (state_q == EMPTY) || (wb_valid_q && wb_ready_i && wb_last_q);
    assign capture_s  = rst_ni && cap_slot_s && gnt_valid_s;
    assign p_ready_o  = capture_s ? gnt_s : '0;

    assign sel_data0_s = p_data0_i[int'(gnt_idx_s)*DataWidth +: DataWidth];
    assign sel_rd_s    = p_rd_i[int'(gnt_idx_s)*RegAddrWidth +: RegAddrWidth];
    assign sel_id_s    = p_id_i[int'(gnt_idx_s)*IdWidth +: IdWidth];
    assign sel_dual_s  = p_dual_wb_i[gnt_idx_s];
    assign sel_err_s   = p_error_i[gnt_idx_s];

`ifdef ACC_RSP_DUAL_WB_EN
    logic [DataWidth-1:0] data1_q;
    logic [DataWidth-1:0] sel_data1_s;
    assign sel_data1_s = p_data1_i[int'(gnt_idx_s)*DataWidth +: DataWidth];
`else
    logic unused_data1_s;
    assign unused_data1_s = ^p_data1_i;
`endif

    // Writeback FSM: outputs are registered and only change on capture or handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= EMPTY;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_id_q    <= '0;
            wb_error_q <= 1'b0;
            wb_last_q  <= 1'b0;
            wb_valid_q <= 1'b0;
`ifdef ACC_RSP_DUAL_WB_EN
            data1_q    <= '0;
`endif
        end else if (capture_s) begin
            state_q    <= BEAT0;
            wb_valid_q <= 1'b1;
            wb_data_q  <= sel_data0_s;
            wb_rd_q    <= sel_rd_s;
            wb_id_q    <= sel_id_s;
`ifdef ACC_RSP_DUAL_WB_EN
            wb_last_q  <= !sel_dual_s;
            wb_error_q <= sel_err_s;
            data1_q    <= sel_data1_s;
`else
            // Without split support a dual response is truncated and flagged.
            wb_last_q  <= 1'b1;
            wb_error_q <= sel_err_s | sel_dual_s;
`endif
        end else begin
            case (state_q)
                BEAT0: begin
                    if (wb_ready_i) begin
`ifdef ACC_RSP_DUAL_WB_EN
                        if (!wb_last_q) begin
                            state_q   <= BEAT1;
                            wb_data_q <= data1_q;
                            wb_rd_q   <= rd_plus_one(wb_rd_q);
                            wb_last_q <= 1'b1;
                        end else begin
                            state_q    <= EMPTY;
                            wb_valid_q <= 1'b0;
                        end
`else
                        state_q    <= EMPTY;
                        wb_valid_q <= 1'b0;
`endif
                    end else begin
                        state_q <= BEAT0;
                    end
                end
                BEAT1: begin
                    if (wb_ready_i) begin
                        state_q    <= EMPTY;
                        wb_valid_q <= 1'b0;
                    end else begin
                        state_q <= BEAT1;
                    end
                end
                EMPTY: begin
                    wb_valid_q <= 1'b0;
                end
                default: begin
                    state_q    <= EMPTY;
                    wb_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign wb_data_o  = wb_data_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_id_o    = wb_id_q;
    assign wb_error_o = wb_error_q;
    assign wb_last_o  = wb_last_q;
    assign wb_valid_o = wb_valid_q;

endmodule

// File: tb/tb_acc_rsp_wb_arbiter.sv
// Randomised scoreboard bench for acc_rsp_wb_arbiter (honours ACC_RSP_DUAL_WB_EN).
module tb_acc_rsp_wb_arbiter;

    localparam int N    = 2;
    localparam int DW   = 32;
    localparam int IW   = 4;
    localparam int MAXI = 200;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [N*DW-1:0]   p_data0_i;
    logic [N*DW-1:0]   p_data1_i;
    logic [N-1:0]      p_dual_wb_i;
    logic [N*IW-1:0]   p_id_i;
    logic [N*5-1:0]    p_rd_i;
    logic [N-1:0]      p_error_i;
    logic [N-1:0]      p_valid_i;
    logic [N-1:0]      p_ready_o;
    logic [DW-1:0]     wb_data_o;
    logic [4:0]        wb_rd_o;
    logic [IW-1:0]     wb_id_o;
    logic              wb_error_o;
    logic              wb_last_o;
    logic              wb_valid_o;
    logic              wb_ready_i;

    always #5 clk = ~clk;

    acc_rsp_wb_arbiter #(.NumRsp(N), .DataWidth(DW), .IdWidth(IW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .p_data0_i   (p_data0_i),
        .p_data1_i   (p_data1_i),
        .p_dual_wb_i (p_dual_wb_i),
        .p_id_i      (p_id_i),
        .p_rd_i      (p_rd_i),
        .p_error_i   (p_error_i),
        .p_valid_i   (p_valid_i),
        .p_ready_o   (p_ready_o),
        .wb_data_o   (wb_data_o),
        .wb_rd_o     (wb_rd_o),
        .wb_id_o     (wb_id_o),
        .wb_error_o  (wb_error_o),
        .wb_last_o   (wb_last_o),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i)
    );

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        dual;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        err;
    } item_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [3:0]  id;
        logic        err;
        logic        last;
    } beat_t;

    item_t    items [N][MAXI];
    int       head [N];
    int       cnt  [N];
    logic [N-1:0] pres;
    logic [N-1:0] acc;
    beat_t    exp_q[$];
    int       ptr;
    int       checks;
    int       errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected writeback beats for one accepted response.
    function automatic void push_item(input item_t it);
        beat_t b;
        b.data = it.d0;
        b.rd   = it.rd;
        b.id   = it.id;
`ifdef ACC_RSP_DUAL_WB_EN
        b.err  = it.err;
        b.last = !it.dual;
        exp_q.push_back(b);
        if (it.dual) begin
            b.data = it.d1;
            b.rd   = 5'((int'(it.rd) + 1) % 32);
            b.last = 1'b1;
            exp_q.push_back(b);
        end
`else
        b.err  = it.err | it.dual;
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endfunction

    // Monitor: whenever the model holds beats, the DUT must present the oldest one.
    always @(negedge clk) begin
        if (rst_ni) begin
            chk("wb_valid", 64'(wb_valid_o), 64'(exp_q.size() != 0));
            if (wb_valid_o && exp_q.size() != 0) begin
                chk("wb_beat", 64'({wb_data_o, wb_rd_o, wb_id_o, wb_error_o, wb_last_o}), 64'(exp_q[0]));
                if (wb_ready_i) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Predictor: runs after the monitor; output slot is free once all model beats are gone.
    always @(negedge clk) begin
        int g;
        int p;
        logic [N-1:0] expv;
        #1;
        if (!rst_ni) begin
            exp_q.delete();
            ptr = 0;
            acc = '0;
            chk("rst_p_ready", 64'(p_ready_o), 64'd0);
        end else begin
            g = -1;
            if (exp_q.size() == 0) begin
                for (int off = 0; off < N; off++) begin
                    p = (ptr + off) % N;
                    if (g < 0 && p_valid_i[p]) g = p;
                end
            end
            expv = '0;
            if (g >= 0) expv[g] = 1'b1;
            chk("p_ready", 64'(p_ready_o), 64'(expv));
            acc = p_valid_i & p_ready_o;
            if (g >= 0) begin
                push_item(items[g][head[g]]);
                ptr = (g + 1) % N;
            end
        end
    end

    task automatic step(input logic rst_val, input int ready_pct);
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (acc[p]) begin
                head[p]++;
                pres[p] = 1'b0;
            end
            if (!pres[p] && head[p] < cnt[p] && $urandom_range(3) != 0) pres[p] = 1'b1;
            if (head[p] < cnt[p]) begin
                p_data0_i[p*DW +: DW] = items[p][head[p]].d0;
                p_data1_i[p*DW +: DW] = items[p][head[p]].d1;
                p_dual_wb_i[p]        = items[p][head[p]].dual;
                p_id_i[p*IW +: IW]    = items[p][head[p]].id;
                p_rd_i[p*5 +: 5]      = items[p][head[p]].rd;
                p_error_i[p]          = items[p][head[p]].err;
            end
            p_valid_i[p] = pres[p];
        end
        acc = '0;
        wb_ready_i = ($urandom_range(99) < ready_pct);
        rst_ni = rst_val;
    endtask

    initial begin
        int budget;
        item_t it;
        checks = 0;
        errors = 0;
        ptr = 0;
        rst_ni = 1'b0;
        wb_ready_i = 1'b0;
        p_valid_i = '0;
        p_data0_i = '0;
        p_data1_i = '0;
        p_dual_wb_i = '0;
        p_id_i = '0;
        p_rd_i = '0;
        p_error_i = '0;
        pres = '0;
        acc = '0;
        for (int p = 0; p < N; p++) begin
            head[p] = 0;
            cnt[p] = MAXI;
            for (int k = 0; k < MAXI; k++) begin
                it.d0   = $urandom;
                it.d1   = $urandom;
                it.dual = 1'($urandom_range(1));
                it.id   = 4'($urandom_range(15));
                it.rd   = ($urandom_range(3) == 0) ? 5'd31 : 5'($urandom_range(31));
                it.err  = ($urandom_range(7) == 0);
                items[p][k] = it;
            end
        end
        items[0][0] = '{d0: 32'hA5A5A5A5, d1: 32'h0, dual: 1'b0, id: 4'd3, rd: 5'd5, err: 1'b0};
        items[0][1] = '{d0: 32'h11, d1: 32'h22, dual: 1'b1, id: 4'd7, rd: 5'd31, err: 1'b0};

        repeat (3) step(1'b0, 0);
        @(negedge clk);
        #2;
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_wb_data",  64'(wb_data_o),  64'd0);
        chk("rst_wb_rd",    64'(wb_rd_o),    64'd0);
        chk("rst_wb_id",    64'(wb_id_o),    64'd0);
        chk("rst_wb_flags", 64'({wb_error_o, wb_last_o}), 64'd0);

        for (int cyc = 0; cyc < 1500; cyc++) begin
            step((cyc == 600 || cyc == 1100) ? 1'b0 : 1'b1,
                 (cyc % 50 < 5) ? 0 : ((cyc < 20) ? 100 : 75));
        end

        budget = 0;
        while ((head[0] < cnt[0] || head[1] < cnt[1] || exp_q.size() != 0) && budget < 3000) begin
            step(1'b1, 100);
            budget++;
        end
        chk("drain_timeout", 64'(budget >= 3000), 64'd0);
        repeat (3) step(1'b1, 100);
        chk("all_consumed", 64'({head[0] == cnt[0], head[1] == cnt[1], exp_q.size() == 0}), 64'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
